// File: rtl/i2c_fsm.sv
// i2c_fsm: single-master write-only I2C engine (START, addr+W, ACK, data, ACK, STOP).
// Open-drain lines: drives 0 or releases to Z; the slave ACK is read back from sda.
module i2c_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    inout  wire                   sda,
    inout  wire                   scl
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] ADDR     = 3'd2;
    localparam logic [2:0] ADDR_ACK = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] DATA_ACK = 3'd5;
    localparam logic [2:0] STOP     = 3'd6;
    localparam int DW = $clog2(CLK_DIV);

    logic [2:0]            state;
    logic [DW-1:0]         div;
    logic [1:0]            q;
    logic [2:0]            bitn;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  nack;
    logic                  tick;
    logic                  cur;
    logic                  sda_low;
    logic                  scl_low;
    logic [7:0]            abyte;
    logic [2:0]            bsel;

    assign tick  = div == DW'(CLK_DIV - 1);
    assign abyte = {addr_r, 1'b0};
    assign bsel  = 3'd7 - bitn;
    assign cur   = state == ADDR ? abyte[bsel] : data_r[bsel];
    assign ready = state == IDLE && !arst;

    always_ff @(posedge clk) begin
        if (arst) begin
            state  <= IDLE;
            div    <= '0;
            q      <= '0;
            bitn   <= '0;
            addr_r <= '0;
            data_r <= '0;
            nack   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state  <= START;
                addr_r <= addr;
                data_r <= data;
            end
            div  <= '0;
            q    <= '0;
            bitn <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick)
                q <= q + 2'd1;
            // ACK is sampled on the last clk of Q2, while SCL is high
            if (tick && q == 2'd2 && (state == ADDR_ACK || state == DATA_ACK))
                nack <= sda;
            if (tick && q == 2'd3) begin
                if (state == ADDR || state == DATA)
                    bitn <= bitn + 3'd1;
                case (state)
                    START:    state <= ADDR;
                    ADDR:     state <= bitn == 3'd7 ? ADDR_ACK : ADDR;
                    ADDR_ACK: state <= nack ? STOP : DATA;
                    DATA:     state <= bitn == 3'd7 ? DATA_ACK : DATA;
                    DATA_ACK: state <= STOP;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        scl_low = (state == IDLE || state == START) ? 1'b0 :
                  state == STOP ? q == 2'd0 : !q[1];
        sda_low = state == START ? q[1] :
                  (state == ADDR || state == DATA) ? !cur :
                  state == STOP ? q != 2'd3 : 1'b0;
    end

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_fsm.sv
// tb_i2c_fsm: scoreboard bench; expected bus bits and ready-low lengths are queued
// at stimulus time and popped as the bus monitor observes SCL rises and ready returns.
module tb_i2c_fsm;
    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data = '0;
    logic       ready;
    wire        sda;
    wire        scl;
    logic       slave_low = 1'b0;

    pullup(sda);
    pullup(scl);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_fsm #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CLK_DIV(4)) dut (
        .clk(clk), .arst(arst), .start(start), .addr(addr), .data(data),
        .ready(ready), .sda(sda), .scl(scl)
    );

    int   checks = 0;
    int   failures = 0;
    bit   exp_bits[$];
    int   exp_len[$];
    int   rise_cnt = 0;
    int   low_cnt = 0;
    int   starts = 0;
    int   stops = 0;
    int   e_starts = 0;
    int   e_stops = 0;
    bit   ack_a = 1'b1;
    bit   ack_d = 1'b1;
    bit   mon_on = 1'b1;
    logic psda = 1'b1;
    logic pscl = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor, slave model and ready-length scoreboard
    always @(negedge clk) begin
        if (arst) begin
            psda = 1'b1;
            pscl = 1'b1;
            low_cnt = 0;
            slave_low = 1'b0;
        end else begin
            if (pscl && scl && psda && !sda) begin
                starts++;
                rise_cnt = 0;
            end else if (pscl && scl && !psda && sda)
                stops++;
            if (!pscl && scl) begin
                rise_cnt++;
                if (mon_on) begin
                    if (exp_bits.size() == 0)
                        check("bit_queue_empty", 32'(exp_bits.size()), 1);
                    else
                        check($sformatf("bus_bit%0d", rise_cnt), 32'(sda), 32'(exp_bits.pop_front()));
                end
            end
            if (pscl && !scl)
                slave_low = rise_cnt == 8 ? ack_a : rise_cnt == 17 ? ack_d : 1'b0;
            if (!ready)
                low_cnt++;
            else if (low_cnt > 0) begin
                if (mon_on) begin
                    if (exp_len.size() == 0)
                        check("len_queue_empty", 32'(exp_len.size()), 1);
                    else
                        check("ready_low_len", low_cnt, exp_len.pop_front());
                end
                low_cnt = 0;
            end
            psda = sda;
            pscl = scl;
        end
    end

    task automatic expect_txn(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad);
        for (int i = 6; i >= 0; i--) exp_bits.push_back(a[i]);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(!aa);
        if (aa) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
            exp_bits.push_back(!ad);
        end
        exp_bits.push_back(1'b0);
        exp_len.push_back(aa ? 320 : 176);
        e_starts++;
        e_stops++;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 1000), 1);
        @(negedge clk);
    endtask

    task automatic finish_checks(input string tag);
        check({tag, "_bits_left"}, 32'(exp_bits.size()), 0);
        check({tag, "_len_left"}, 32'(exp_len.size()), 0);
        check({tag, "_starts"}, starts, e_starts);
        check({tag, "_stops"}, stops, e_stops);
    endtask

    task automatic run(input string tag, input logic [6:0] a, input logic [7:0] d,
                       input bit aa, input bit ad);
        expect_txn(a, d, aa, ad);
        @(negedge clk);
        addr = a;
        data = d;
        ack_a = aa;
        ack_d = ad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(ready), 0);
        wait_ready({tag, "_timeout"});
        finish_checks(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_sda", 32'(sda), 1);
        check("rst_scl", 32'(scl), 1);
        arst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 1);
        check("post_rst_sda", 32'(sda), 1);

        run("full", 7'h50, 8'hA5, 1'b1, 1'b1);
        run("addr_nack", 7'h50, 8'hA5, 1'b0, 1'b1);
        run("data_nack", 7'h2B, 8'h96, 1'b1, 1'b0);

        // back-to-back: start held, inputs changed mid-transaction
        expect_txn(7'h50, 8'hA5, 1'b1, 1'b1);
        expect_txn(7'h23, 8'h3C, 1'b1, 1'b1);
        @(negedge clk);
        addr = 7'h50;
        data = 8'hA5;
        ack_a = 1'b1;
        ack_d = 1'b1;
        start = 1'b1;
        @(negedge clk);
        addr = 7'h23;
        data = 8'h3C;
        begin
            int n = 0;
            while (!ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_timeout", 32'(n < 1000), 1);
        end
        check("b2b_ready_pulse", 32'(ready), 1);
        @(negedge clk);
        check("b2b_reaccept", 32'(ready), 0);
        start = 1'b0;
        addr = 7'h7F;
        data = 8'hFF;
        wait_ready("b2b_second_timeout");
        finish_checks("b2b");

        // abort mid-ADDR (bit 2, Q0) with reset
        mon_on = 1'b0;
        @(negedge clk);
        addr = 7'h50;
        data = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("abort_scl_low", 32'(scl), 0);
        arst = 1'b1;
        @(negedge clk);
        check("abort_sda", 32'(sda), 1);
        check("abort_scl", 32'(scl), 1);
        check("abort_ready", 32'(ready), 0);
        arst = 1'b0;
        @(negedge clk);
        check("abort_ready_back", 32'(ready), 1);
        e_starts++;
        check("abort_no_stop", stops, e_stops);
        mon_on = 1'b1;
        run("after_abort", 7'h11, 8'h5A, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
